// File: rtl/mcpu_ctrl_fsm.sv
// Purpose : main sequencer for the multi-cycle CPU datapath. It walks the
//           fetch / decode / execute / memory / writeback states and drives
//           every datapath write enable and mux select.
// Latency : one state per clock. The outputs decode the current state, and in
//           the memory states they also decode mem_ready.
// Backpressure: FETCH, MRD and MWR hold while mem_ready is low, with every
//           enable held at 0. mem_ready is ignored in all other states.
//
// Ports
//   clk, reset          rising-edge clock; synchronous active-high reset. The
//                       reset cycle itself forces every output to 0.
//   opcode, funct       IR[31:26] / IR[5:0] from the instruction register.
//   zero                ALU zero flag. Branch resolution happens in the
//                       datapath through bne_sel, so the FSM does not use it.
//   mem_ready / mem_req memory wait-state handshake.
//   *_we                write enables for PC, IR, A, B, BEN, regfile, memory.
//   mem_in, reg_in, rw_sel, alu_src_a, alu_src_b, alu_op, pc_src, bne_sel
//                       datapath mux selects. Any select that a state does not
//                       use is driven to 0.
//   illegal             sticky trap flag. It stays high in TRAP until reset.
//   state               current state, for debug.
//   cyc_cnt, ret_cnt    performance counters.
//
// Configuration macro: MCPU_PERF_CNT_EN
//   When defined, the cycle counter and the retired-instruction counter are
//   built. When undefined, both counters read 0 and no counter flops exist.

module mcpu_ctrl_fsm #(
    parameter int STATE_W  = 4,
    parameter int LINK_REG = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               pc_we,
    output logic               ir_we,
    output logic               a_we,
    output logic               b_we,
    output logic               ben_we,
    output logic               reg_we,
    output logic               mem_we,
    output logic               mem_in,
    output logic               reg_in,
    output logic [1:0]         rw_sel,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               bne_sel,
    output logic               illegal,
    output logic [STATE_W-1:0] state,
    output logic [31:0]        cyc_cnt,
    output logic [31:0]        ret_cnt
);

    // Parameter sanity: 14 states need 4 bits. The link register is a 5-bit
    // regfile address that the datapath selects when rw_sel is 2.
    generate
        if (STATE_W < 4) begin : g_bad_state_w
            $error("mcpu_ctrl_fsm: STATE_W must be at least 4");
        end
        if (LINK_REG < 0 || LINK_REG > 31) begin : g_bad_link_reg
            $error("mcpu_ctrl_fsm: LINK_REG must be a 5-bit register address");
        end
    endgenerate

    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MADDR  = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MRD    = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MWR    = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXR    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_WBR    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_EXI    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_WBI    = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_BR     = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_JMP    = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_JAL    = STATE_W'(12);
    localparam logic [STATE_W-1:0] S_TRAP   = STATE_W'(13);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    logic [STATE_W-1:0] state_q, state_d;

    // Branch resolution is done in the datapath, so the zero flag goes nowhere.
    logic unused_zero;
    assign unused_zero = zero;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     state_d = S_MADDR;
                    OP_ADDI, OP_XORI: state_d = S_EXI;
                    OP_BEQ, OP_BNE:   state_d = S_BR;
                    OP_J:             state_d = S_JMP;
                    OP_JAL:           state_d = S_JAL;
                    OP_R: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_SLT: state_d = S_EXR;
                            FN_JR:                  state_d = S_JMP;
                            default:                state_d = S_TRAP;
                        endcase
                    end
                    default:          state_d = S_TRAP;
                endcase
            end
            S_MADDR:  state_d = (opcode == OP_SW) ? S_MWR : S_MRD;
            S_MRD:    if (mem_ready) state_d = S_MWB;
            S_MWR:    if (mem_ready) state_d = S_FETCH;
            S_EXR:    state_d = S_WBR;
            S_EXI:    state_d = S_WBI;
            S_MWB, S_WBR, S_WBI, S_BR, S_JMP, S_JAL: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            // Unused encodings fall back to fetch instead of locking up.
            default:  state_d = S_FETCH;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        mem_req   = 1'b0;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        a_we      = 1'b0;
        b_we      = 1'b0;
        ben_we    = 1'b0;
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        mem_in    = 1'b0;
        reg_in    = 1'b0;
        rw_sel    = 2'd0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        alu_op    = ALU_ADD;
        pc_src    = 2'd0;
        bne_sel   = 1'b0;
        illegal   = 1'b0;
        state     = reset ? S_FETCH : state_q;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    // PC+4 is computed every fetch cycle. It commits only
                    // when the instruction word arrives.
                    mem_req   = 1'b1;
                    alu_src_b = 2'd3;
                    pc_src    = 2'd2;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                S_DECODE: begin
                    // A/B read the regfile. BEN latches PC+4 + (imm<<2).
                    a_we   = 1'b1;
                    b_we   = 1'b1;
                    ben_we = 1'b1;
                end
                S_MADDR: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd1;
                end
                S_MRD: begin
                    mem_req = 1'b1;
                    mem_in  = 1'b1;
                end
                S_MWB: begin
                    reg_we = 1'b1;
                    rw_sel = 2'd1;
                end
                S_MWR: begin
                    // The store strobe fires once, in the cycle memory accepts it.
                    mem_req = 1'b1;
                    mem_in  = 1'b1;
                    mem_we  = mem_ready;
                end
                S_EXR: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    case (funct)
                        FN_SUB:  alu_op = ALU_SUB;
                        FN_SLT:  alu_op = ALU_SLT;
                        default: alu_op = ALU_ADD;
                    endcase
                end
                S_WBR: begin
                    reg_we = 1'b1;
                    reg_in = 1'b1;
                end
                S_EXI: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd1;
                    alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
                end
                S_WBI: begin
                    reg_we = 1'b1;
                    reg_in = 1'b1;
                    rw_sel = 2'd1;
                end
                S_BR: begin
                    // The compare runs here. The datapath chooses between BEN
                    // and PC+4 using zero and bne_sel.
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    alu_op    = ALU_SUB;
                    bne_sel   = opcode[0];
                    pc_we     = 1'b1;
                end
                S_JMP: begin
                    pc_we = 1'b1;
                    if (opcode == OP_J) begin
                        pc_src = 2'd1;
                    end else begin
                        // JR: rt is 0 in the encoding, so A ^ B passes A
                        // straight through to the PC.
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd2;
                        alu_op    = ALU_XOR;
                        pc_src    = 2'd2;
                    end
                end
                S_JAL: begin
                    // The ALU register still holds PC+4 from decode. It is
                    // written to the link register in the same cycle as the jump.
                    reg_we = 1'b1;
                    reg_in = 1'b1;
                    rw_sel = 2'd2;
                    pc_src = 2'd1;
                    pc_we  = 1'b1;
                end
                S_TRAP: illegal = 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------ perf counters
`ifdef MCPU_PERF_CNT_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] ret_cnt_q, ret_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q + 32'd1;
        ret_cnt_d = ret_cnt_q;
        // An instruction retires when control returns to FETCH. Re-entry
        // caused by reset is excluded because reset clears the counter anyway.
        if (state_q != S_FETCH && state_d == S_FETCH) begin
            ret_cnt_d = ret_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt_q <= 32'd0;
            ret_cnt_q <= 32'd0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    assign cyc_cnt = reset ? 32'd0 : cyc_cnt_q;
    assign ret_cnt = reset ? 32'd0 : ret_cnt_q;
`else
    assign cyc_cnt = 32'd0;
    assign ret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Testbench for mcpu_ctrl_fsm.
// The driver issues instructions one cycle at a time. For each cycle it pushes
// the expected output bundle into a queue. A monitor pops one entry at every
// falling edge and compares it against the DUT.

module tb_mcpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode, funct;
    logic        zero, mem_ready;
    logic        mem_req, pc_we, ir_we, a_we, b_we, ben_we, reg_we, mem_we;
    logic        mem_in, reg_in, bne_sel, illegal;
    logic [1:0]  rw_sel, alu_src_a, alu_src_b, pc_src;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic [31:0] cyc_cnt, ret_cnt;

    always #5 clk = ~clk;

    mcpu_ctrl_fsm #(.STATE_W(4), .LINK_REG(31)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .pc_we(pc_we), .ir_we(ir_we),
        .a_we(a_we), .b_we(b_we), .ben_we(ben_we), .reg_we(reg_we), .mem_we(mem_we),
        .mem_in(mem_in), .reg_in(reg_in), .rw_sel(rw_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .bne_sel(bne_sel),
        .illegal(illegal), .state(state), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
    );

`ifdef MCPU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  state;
        logic        pc_we, ir_we, a_we, b_we, ben_we, reg_we, mem_we;
        logic        mem_req, mem_in, reg_in;
        logic [1:0]  rw_sel, src_a, src_b;
        logic [2:0]  alu_op;
        logic [1:0]  pc_src;
        logic        bne_sel, illegal;
        logic [31:0] cyc, ret;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc_m  = 0;   // non-reset cycles since the last reset
    int    ret_m  = 0;   // instructions completed since the last reset

    // Legal instructions as (opcode, funct) pairs. funct is only meaningful
    // for opcode 00h.
    logic [5:0] lop[13] = '{6'h23, 6'h2B, 6'h08, 6'h0E, 6'h04, 6'h05, 6'h02,
                            6'h03, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23};
    logic [5:0] lfn[13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                            6'h00, 6'h20, 6'h22, 6'h2A, 6'h08, 6'h00};

    // ------------------------------------------------------------ monitor
    obs_t  mon_e, mon_a;
    string mon_n;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            mon_a = '0;
            mon_a.state   = state;   mon_a.pc_we  = pc_we;   mon_a.ir_we  = ir_we;
            mon_a.a_we    = a_we;    mon_a.b_we   = b_we;    mon_a.ben_we = ben_we;
            mon_a.reg_we  = reg_we;  mon_a.mem_we = mem_we;  mon_a.mem_req = mem_req;
            mon_a.mem_in  = mem_in;  mon_a.reg_in = reg_in;  mon_a.rw_sel = rw_sel;
            mon_a.src_a   = alu_src_a; mon_a.src_b = alu_src_b; mon_a.alu_op = alu_op;
            mon_a.pc_src  = pc_src;  mon_a.bne_sel = bne_sel; mon_a.illegal = illegal;
            mon_a.cyc     = cyc_cnt; mon_a.ret    = ret_cnt;
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL %s @%0t: got %h expected %h", mon_n, $time, mon_a, mon_e);
            end
        end
    end

    // -------------------------------------------------- reference helpers
    function automatic obs_t blank(input logic [3:0] st);
        obs_t o = '0;
        o.state = st;
        o.cyc   = PERF ? 32'(cyc_m) : 32'd0;
        o.ret   = PERF ? 32'(ret_m) : 32'd0;
        return o;
    endfunction

    task automatic step(input obs_t e, input logic rdy, input string nm, input bit retire);
        mem_ready = rdy;
        zero      = 1'($urandom_range(0, 1));
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        if (reset) begin
            cyc_m = 0;
            ret_m = 0;
        end else begin
            cyc_m++;
            if (retire) ret_m++;
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step('0, rnd(), "reset", 1'b0);
        reset = 1'b0;
    endtask

    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input int fw);
        obs_t e;
        opcode = 6'($urandom);   // IR is not loaded yet, so its contents are don't-care
        funct  = 6'($urandom);
        for (int i = 0; i < fw; i++) begin
            e = blank(4'd0); e.mem_req = 1; e.src_b = 2'd3; e.pc_src = 2'd2;
            step(e, 1'b0, "fetch_wait", 1'b0);
        end
        e = blank(4'd0); e.mem_req = 1; e.src_b = 2'd3; e.pc_src = 2'd2;
        e.ir_we = 1; e.pc_we = 1;
        step(e, 1'b1, "fetch", 1'b0);
        opcode = op;
        funct  = fn;
        e = blank(4'd1); e.a_we = 1; e.b_we = 1; e.ben_we = 1;
        step(e, rnd(), "decode", 1'b0);
    endtask

    task automatic do_trap(input int n);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            e = blank(4'd13); e.illegal = 1;
            step(e, rnd(), "trap", 1'b0);
        end
        do_reset(1);
    endtask

    // Runs one full instruction. Expectations come from the instruction's class.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw);
        obs_t e;
        fetch_decode(op, fn, fw);
        case (op)
            6'h23, 6'h2B: begin
                e = blank(4'd2); e.src_a = 1; e.src_b = 1;
                step(e, rnd(), "maddr", 1'b0);
                if (op == 6'h23) begin
                    for (int i = 0; i <= mw; i++) begin
                        e = blank(4'd3); e.mem_req = 1; e.mem_in = 1;
                        step(e, (i == mw), "mrd", 1'b0);
                    end
                    e = blank(4'd4); e.reg_we = 1; e.rw_sel = 2'd1;
                    step(e, rnd(), "mwb", 1'b1);
                end else begin
                    for (int i = 0; i <= mw; i++) begin
                        e = blank(4'd5); e.mem_req = 1; e.mem_in = 1;
                        e.mem_we = (i == mw);
                        step(e, (i == mw), "mwr", (i == mw));
                    end
                end
            end
            6'h08, 6'h0E: begin
                e = blank(4'd8); e.src_a = 1; e.src_b = 1;
                e.alu_op = (op == 6'h0E) ? 3'd2 : 3'd0;
                step(e, rnd(), "exi", 1'b0);
                e = blank(4'd9); e.reg_we = 1; e.reg_in = 1; e.rw_sel = 2'd1;
                step(e, rnd(), "wbi", 1'b1);
            end
            6'h04, 6'h05: begin
                e = blank(4'd10); e.src_a = 1; e.src_b = 2; e.alu_op = 3'd1;
                e.bne_sel = (op == 6'h05); e.pc_src = 2'd0; e.pc_we = 1;
                step(e, rnd(), "br", 1'b1);
            end
            6'h02: begin
                e = blank(4'd11); e.pc_src = 2'd1; e.pc_we = 1;
                step(e, rnd(), "j", 1'b1);
            end
            6'h03: begin
                e = blank(4'd12); e.reg_we = 1; e.reg_in = 1; e.rw_sel = 2'd2;
                e.pc_src = 2'd1; e.pc_we = 1;
                step(e, rnd(), "jal", 1'b1);
            end
            6'h00: begin
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) begin
                    e = blank(4'd6); e.src_a = 1; e.src_b = 2;
                    e.alu_op = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0;
                    step(e, rnd(), "exr", 1'b0);
                    e = blank(4'd7); e.reg_we = 1; e.reg_in = 1;
                    step(e, rnd(), "wbr", 1'b1);
                end else if (fn == 6'h08) begin
                    e = blank(4'd11); e.src_a = 1; e.src_b = 2; e.alu_op = 3'd2;
                    e.pc_src = 2'd2; e.pc_we = 1;
                    step(e, rnd(), "jr", 1'b1);
                end else begin
                    do_trap(3);
                end
            end
            default: do_trap(3);
        endcase
    endtask

    // ----------------------------------------------------------- stimulus
    initial begin
        obs_t e;
        int   k;
        reset = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        // Directed cases.
        run_instr(6'h23, 6'h00, 0, 3);   // LW, three wait cycles in MRD
        run_instr(6'h05, 6'h00, 1, 0);   // BNE
        run_instr(6'h04, 6'h00, 0, 0);   // BEQ
        run_instr(6'h03, 6'h00, 0, 0);   // JAL
        run_instr(6'h02, 6'h00, 2, 0);   // J
        run_instr(6'h00, 6'h08, 0, 0);   // JR
        run_instr(6'h00, 6'h2A, 0, 0);   // SLT
        run_instr(6'h0E, 6'h00, 0, 0);   // XORI
        run_instr(6'h2B, 6'h00, 0, 2);   // SW with two wait cycles

        // Randomized legal traffic.
        for (int i = 0; i < 120; i++) begin
            k = $urandom_range(0, 12);
            run_instr(lop[k], lfn[k], $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset arrives while SW waits in MWR. mem_ready is high in the reset
        // cycle but must not produce a store.
        fetch_decode(6'h2B, 6'h00, 0);
        e = blank(4'd2); e.src_a = 1; e.src_b = 1;
        step(e, 1'b0, "maddr", 1'b0);
        e = blank(4'd5); e.mem_req = 1; e.mem_in = 1;
        step(e, 1'b0, "mwr_wait", 1'b0);
        reset = 1'b1;
        step('0, 1'b1, "reset_in_mwr", 1'b0);
        reset = 1'b0;
        run_instr(6'h08, 6'h00, 0, 0);   // ADDI after reset starts from FETCH

        // Illegal opcode: trap held for 10 cycles, then reset.
        fetch_decode(6'h3F, 6'h00, 0);
        do_trap(10);
        run_instr(6'h00, 6'h20, 0, 0);   // ADD after the trap has been cleared
        run_instr(6'h00, 6'h21, 0, 0);   // illegal R-type funct

        // Random mix that includes random (mostly illegal) opcodes.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                run_instr(6'($urandom), 6'($urandom), $urandom_range(0, 1), $urandom_range(0, 2));
            end else begin
                k = $urandom_range(0, 12);
                run_instr(lop[k], lfn[k], $urandom_range(0, 1), $urandom_range(0, 2));
            end
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
